// File: rtl/i2c_slave_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_tx_byte
// Description : I2C slave transmit byte engine. Serializes one byte MSB first
//               onto SDA, changing the bit only while SCL is low. After the
//               last data bit it releases SDA and samples the master's
//               ACK/NACK on the 9th SCL pulse.
// Ports       : clk, n_rst          - clock / async active-low reset
//               scl_sync, sda_sync - synchronized bus inputs
//               load_data, tx_data - request to send a byte, and the byte
//               start_found,
//               stop_found         - bus condition pulses (abort a byte)
//               sda_out            - open-drain drive (0 = pull low)
//               tx_busy            - byte in progress
//               byte_done,
//               ack_received,
//               nack_received      - completion pulses at end of ACK clock
//               tx_abort           - byte killed by START/STOP
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_tx_byte #(
  parameter int NUM_BITS = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                scl_sync,
  input  logic                sda_sync,
  input  logic                load_data,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                start_found,
  input  logic                stop_found,
  output logic                sda_out,
  output logic                tx_busy,
  output logic                byte_done,
  output logic                ack_received,
  output logic                nack_received,
  output logic                tx_abort
);

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_wait_low = 3'd1;
  localparam logic [2:0] c_st_shift    = 3'd2;
  localparam logic [2:0] c_st_ack_wait = 3'd3;
  localparam logic [2:0] c_st_ack_end  = 3'd4;

  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(NUM_BITS - 1);

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] w_shift_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_scl_prev;
  logic                r_ack_bit;
  logic                w_ack_bit_nxt;
  logic                r_sda_out;
  logic                w_sda_out_nxt;
  logic                r_tx_busy;
  logic                w_tx_busy_nxt;
  logic                r_byte_done;
  logic                w_byte_done_nxt;
  logic                r_ack_rx;
  logic                w_ack_rx_nxt;
  logic                r_nack_rx;
  logic                w_nack_rx_nxt;
  logic                r_tx_abort;
  logic                w_tx_abort_nxt;

  logic w_fall;
  logic w_rise;
  logic w_abort;

  assign w_fall  = r_scl_prev & ~scl_sync;
  assign w_rise  = ~r_scl_prev & scl_sync;
  // A bus START/STOP kills any byte in flight and outranks every other event.
  assign w_abort = (start_found | stop_found) & (r_state != c_st_idle);

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= c_st_idle;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_scl_prev  <= 1'b1;
      r_ack_bit   <= 1'b1;
      r_sda_out   <= 1'b1;
      r_tx_busy   <= 1'b0;
      r_byte_done <= 1'b0;
      r_ack_rx    <= 1'b0;
      r_nack_rx   <= 1'b0;
      r_tx_abort  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_scl_prev  <= scl_sync;
      r_ack_bit   <= w_ack_bit_nxt;
      r_sda_out   <= w_sda_out_nxt;
      r_tx_busy   <= w_tx_busy_nxt;
      r_byte_done <= w_byte_done_nxt;
      r_ack_rx    <= w_ack_rx_nxt;
      r_nack_rx   <= w_nack_rx_nxt;
      r_tx_abort  <= w_tx_abort_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (load_data) begin
            // SCL already low: first bit can go out immediately.
            w_state_nxt = scl_sync ? c_st_wait_low : c_st_shift;
          end
        end
        c_st_wait_low: if (w_fall) w_state_nxt = c_st_shift;
        c_st_shift: begin
          if (w_fall && (r_cnt == c_last_bit)) w_state_nxt = c_st_ack_wait;
        end
        c_st_ack_wait: if (w_rise) w_state_nxt = c_st_ack_end;
        c_st_ack_end:  if (w_fall) w_state_nxt = c_st_idle;
        default:       w_state_nxt = c_st_idle;
      endcase
    end
  end

  // Datapath and output next-values.
  always_comb begin
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_ack_bit_nxt   = r_ack_bit;
    w_byte_done_nxt = 1'b0;
    w_ack_rx_nxt    = 1'b0;
    w_nack_rx_nxt   = 1'b0;
    w_tx_abort_nxt  = 1'b0;
    if (w_abort) begin
      w_tx_abort_nxt = 1'b1;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (load_data) begin
            w_shift_nxt = tx_data;
            w_cnt_nxt   = '0;
          end
        end
        c_st_shift: begin
          if (w_fall) begin
            if (r_cnt == c_last_bit) begin
              w_cnt_nxt = '0;
            end else begin
              w_cnt_nxt   = r_cnt + CNT_W'(1);
              w_shift_nxt = {r_shift[NUM_BITS-2:0], 1'b0};
            end
          end
        end
        c_st_ack_wait: if (w_rise) w_ack_bit_nxt = sda_sync;
        c_st_ack_end: begin
          if (w_fall) begin
            w_byte_done_nxt = 1'b1;
            w_ack_rx_nxt    = ~r_ack_bit;
            w_nack_rx_nxt   = r_ack_bit;
          end
        end
        default: ;
      endcase
    end
    // SDA is driven only while shifting data; released everywhere else.
    w_sda_out_nxt = (w_state_nxt == c_st_shift) ? w_shift_nxt[NUM_BITS-1] : 1'b1;
    w_tx_busy_nxt = (w_state_nxt != c_st_idle);
  end

  assign sda_out       = r_sda_out;
  assign tx_busy       = r_tx_busy;
  assign byte_done     = r_byte_done;
  assign ack_received  = r_ack_rx;
  assign nack_received = r_nack_rx;
  assign tx_abort      = r_tx_abort;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_tx_byte
// Description : Scoreboard bench for i2c_slave_tx_byte. Stimulus pushes the
//               expected SDA bit for every SCL-high window and the expected
//               completion/abort event (with its clock cycle); a monitor pops
//               and compares whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_tx_byte;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       scl_sync;
  logic       sda_sync;
  logic       load_data;
  logic [7:0] tx_data;
  logic       start_found;
  logic       stop_found;
  logic       sda_out;
  logic       tx_busy;
  logic       byte_done;
  logic       ack_received;
  logic       nack_received;
  logic       tx_abort;

  typedef struct {
    int code;  // 0 = ACK, 1 = NACK, 2 = abort
    int cyc;
  } ev_t;

  int  exp_bits[$];
  ev_t exp_ev[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;
  logic mon_scl_q = 1'b0;

  i2c_slave_tx_byte #(.NUM_BITS(8), .CNT_W(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .scl_sync      (scl_sync),
    .sda_sync      (sda_sync),
    .load_data     (load_data),
    .tx_data       (tx_data),
    .start_found   (start_found),
    .stop_found    (stop_found),
    .sda_out       (sda_out),
    .tx_busy       (tx_busy),
    .byte_done     (byte_done),
    .ack_received  (ack_received),
    .nack_received (nack_received),
    .tx_abort      (tx_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling clock edge, away from the active edge.
  always @(negedge clk) begin : mon
    ev_t e;
    int  code;
    if (n_rst) begin
      if (scl_sync && !mon_scl_q) begin
        if (exp_bits.size() == 0) begin
          chk("unexpected_scl_window", 1, 0);
        end else begin
          chk("sda_bit", int'(sda_out), exp_bits.pop_front());
        end
      end
      mon_scl_q = scl_sync;
      if (byte_done || ack_received || nack_received || tx_abort) begin
        if (tx_abort && !byte_done && !ack_received && !nack_received)
          code = 2;
        else if (byte_done && ack_received && !nack_received && !tx_abort)
          code = 0;
        else if (byte_done && nack_received && !ack_received && !tx_abort)
          code = 1;
        else
          code = 3;
        if (exp_ev.size() == 0) begin
          chk("unexpected_event", code, -1);
        end else begin
          e = exp_ev.pop_front();
          chk("event_kind", code, e.code);
          chk("event_cycle", cyc, e.cyc);
          chk("busy_at_event", int'(tx_busy), 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] d);
    load_data = 1'b1;
    tx_data   = d;
    tick(1);
    load_data = 1'b0;
  endtask

  // SCL pulses for data bits [from, to) of d, each 10 clk high / 10 clk low.
  task automatic bits(input logic [7:0] d, input int from, input int to);
    for (int i = from; i < to; i++) begin
      exp_bits.push_back(int'(d[7-i]));
      scl_sync = 1'b1;
      tick(10);
      scl_sync = 1'b0;
      tick(10);
    end
  endtask

  // 9th pulse: slave releases SDA, master drives lvl; event 1 clk after fall.
  task automatic ack_slot(input logic lvl);
    exp_bits.push_back(1);
    sda_sync = lvl;
    scl_sync = 1'b1;
    tick(10);
    scl_sync = 1'b0;
    exp_ev.push_back('{code: (lvl ? 1 : 0), cyc: cyc + 1});
    tick(10);
    sda_sync = 1'b1;
  endtask

  initial begin
    n_rst       = 1'b0;
    scl_sync    = 1'b0;
    sda_sync    = 1'b1;
    load_data   = 1'b0;
    tx_data     = 8'h00;
    start_found = 1'b0;
    stop_found  = 1'b0;
    #23;
    chk("rst_sda_out", int'(sda_out), 1);
    chk("rst_tx_busy", int'(tx_busy), 0);
    chk("rst_pulses", int'({byte_done, ack_received, nack_received, tx_abort}), 0);
    n_rst = 1'b1;
    tick(3);

    // ACK case, 8'hA5 loaded with SCL low.
    load(8'hA5);
    chk("busy_after_load", int'(tx_busy), 1);
    chk("msb_after_load", int'(sda_out), 1);
    tick(4);
    bits(8'hA5, 0, 8);
    ack_slot(1'b0);
    chk("busy_after_ack", int'(tx_busy), 0);
    tick(3);

    // NACK case, 8'h3C.
    load(8'h3C);
    tick(5);
    bits(8'h3C, 0, 8);
    ack_slot(1'b1);
    tick(3);

    // SCL high at load: WAIT_LOW keeps SDA released until the first fall.
    exp_bits.push_back(1);
    scl_sync = 1'b1;
    tick(3);
    load(8'h80);
    tick(5);
    chk("wait_low_sda", int'(sda_out), 1);
    chk("wait_low_busy", int'(tx_busy), 1);
    scl_sync = 1'b0;
    tick(10);
    bits(8'h80, 0, 8);
    ack_slot(1'b0);
    tick(3);

    // Load while busy is ignored.
    load(8'hFF);
    tick(5);
    bits(8'hFF, 0, 3);
    load(8'h00);
    bits(8'hFF, 3, 8);
    ack_slot(1'b0);
    tick(3);

    // Abort by STOP after 4 bits, then a fresh byte from the MSB.
    load(8'h5A);
    tick(5);
    bits(8'h5A, 0, 4);
    stop_found = 1'b1;
    exp_ev.push_back('{code: 2, cyc: cyc + 1});
    tick(1);
    stop_found = 1'b0;
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_sda", int'(sda_out), 1);
    tick(5);
    load(8'h5A);
    chk("reload_msb", int'(sda_out), 0);
    tick(5);
    bits(8'h5A, 0, 8);
    ack_slot(1'b0);
    tick(3);

    // Asynchronous reset during bit 5 of 8'hA5 (bit value 0).
    load(8'hA5);
    tick(5);
    bits(8'hA5, 0, 4);
    chk("bit5_low", int'(sda_out), 0);
    exp_bits.push_back(0);
    scl_sync = 1'b1;
    tick(3);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("async_rst_sda", int'(sda_out), 1);
    chk("async_rst_busy", int'(tx_busy), 0);
    #8 n_rst = 1'b1;
    tick(3);
    scl_sync = 1'b0;
    tick(20);

    chk("bits_left", exp_bits.size(), 0);
    chk("events_left", exp_ev.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_tx_byte.md
Name: i2c_slave_tx_byte

Overview:
Transmit-side byte engine for the I2C slave. It serializes one byte from the data path onto SDA, MSB first, and changes bits only while SCL is low. It then releases SDA and samples the master's ACK/NACK on the 9th SCL pulse. It is the counterpart of the slave receive shifter and sits between the synchronized bus inputs and the slave controller FSM. An internal bit counter, equivalent to a flex counter with rollover 8, tracks the bits.

Parameters:
NUM_BITS, 8, number of data bits shifted per byte (MSB first)
CNT_W, 4, width of internal bit counter; must hold NUM_BITS

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
scl_sync  input  1  SCL, already 2-flop synchronized to clk
sda_sync  input  1  SDA, already 2-flop synchronized; used for ACK sampling
load_data  input  1  one-cycle request to start sending tx_data
tx_data  input  NUM_BITS  byte to transmit; captured on accepted load_data
start_found  input  1  one-cycle pulse: START/repeated START detected on bus
stop_found  input  1  one-cycle pulse: STOP detected on bus
sda_out  output  1  SDA drive: 0 = pull low, 1 = release (open-drain)
tx_busy  output  1  high from accepted load until byte completes or aborts
byte_done  output  1  one-cycle pulse at end of ACK clock
ack_received  output  1  one-cycle pulse with byte_done when master ACKed (SDA=0)
nack_received  output  1  one-cycle pulse with byte_done when master NACKed (SDA=1)
tx_abort  output  1  one-cycle pulse when a START/STOP kills a byte in progress

Behaviour:
- Reset (n_rst=0, async): state IDLE, sda_out=1, tx_busy=0, all pulses 0, shift reg=0, bit count=0, scl_prev=1.
- Edge detect: scl_prev is a register of scl_sync. fall = scl_prev & ~scl_sync; rise = ~scl_prev & scl_sync. All actions on an edge take effect at the next clk edge, 1 clk after the edge is visible.
- States: IDLE, WAIT_LOW, SHIFT, ACK_WAIT, ACK_END.
- IDLE: sda_out=1.
  - load_data=1: capture tx_data, clear the count, set tx_busy=1.
  - If scl_sync=0 in that cycle, go to SHIFT and drive sda_out=tx_data[MSB] on the next clk.
  - Otherwise go to WAIT_LOW.
- WAIT_LOW: sda_out=1. On fall, go to SHIFT and drive the MSB.
- SHIFT: sda_out = shift[MSB]. On each fall, increment the count.
  - If the count was NUM_BITS-1, go to ACK_WAIT and release sda_out=1.
  - Otherwise shift left by 1, so the next bit appears 1 clk after the fall.
  - The bit never changes while scl_sync=1.
- ACK_WAIT: sda_out=1. On rise, latch ack_bit=sda_sync and go to ACK_END.
- ACK_END: on fall, for exactly 1 clk:
  - pulse byte_done;
  - pulse ack_received if ack_bit=0, else nack_received;
  - clear tx_busy and go to IDLE.
- load_data while tx_busy=1 is ignored; the shift register and state are unchanged.
- load_data in the same clk as the ACK_END completion is ignored; it must be reissued.
- start_found or stop_found while tx_busy=1 (any non-IDLE state) has priority over every other event in that cycle.
  - Next clk: IDLE, sda_out=1, tx_busy=0, tx_abort=1 for 1 clk, no byte_done.
  - In IDLE these inputs have no effect.
- Simultaneous fall and abort: abort wins.
- Simultaneous load_data and start_found in IDLE: load is accepted.
- Count wraps to 0 on each accepted load. It never exceeds NUM_BITS-1 in SHIFT.
- ack_received, nack_received and byte_done are mutually consistent: byte_done = ack_received | nack_received.

Test Plan:
- ACK case: reset, scl_sync=0, load 8'hA5, then 9 SCL pulses (10 clk high / 10 clk low), master holding SDA=0 on the 9th.
  - sda_out during the 8 SCL-high windows = 1,0,1,0,0,1,0,1.
  - sda_out=1 during the 9th.
  - byte_done and ack_received pulse 1 clk after the 9th fall; tx_busy drops the same clk.
- NACK case: load 8'h3C, master leaves SDA=1 on the 9th pulse.
  - bits 0,0,1,1,1,1,0,0 on sda_out.
  - nack_received=1 and ack_received=0 with byte_done.
- SCL high at load: load 8'h80 while scl_sync=1.
  - sda_out stays 1 (WAIT_LOW) until the first fall.
  - sda_out=1 (MSB) 1 clk after the fall, then 0 for the remaining 7 bits.
- Load while busy: load 8'hFF, then assert load_data with tx_data=8'h00 after 3 bits.
  - Ignored; the remaining 5 bits still come from 8'hFF (all 1).
- Abort: stop_found pulse after 4 bits of 8'h5A.
  - Next clk: sda_out=1, tx_busy=0, tx_abort=1 for 1 clk.
  - No byte_done.
  - A fresh load of 8'h5A then transmits correctly from the MSB.
- Async reset mid-byte: drop n_rst mid-clock during bit 5 while sda_out=0.
  - sda_out=1 and tx_busy=0 immediately, without waiting for a clk edge.
  - All pulses stay 0 after release.
